// File: rtl/ds1302_ctrl_module_pkg.sv
// Shared encodings for the DS1302 command sequencer: register address bytes,
// write-protect values, engine opcodes, FSM/mode encodings and the
// sequence-table entry layout.
package ds1302_ctrl_module_pkg;

    // Engine opcodes as seen on func_start_sig
    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;

    // DS1302 command/address bytes
    localparam logic [7:0] ADDR_WP    = 8'h8E;
    localparam logic [7:0] ADDR_SEC_W = 8'h80;
    localparam logic [7:0] ADDR_SEC_R = 8'h81;
    localparam logic [7:0] ADDR_MIN_W = 8'h82;
    localparam logic [7:0] ADDR_MIN_R = 8'h83;
    localparam logic [7:0] ADDR_HR_W  = 8'h84;
    localparam logic [7:0] ADDR_HR_R  = 8'h85;

    // Write-protect register values
    localparam logic [7:0] WP_OFF = 8'h00;
    localparam logic [7:0] WP_ON  = 8'h80;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT,
        ST_ISSUE,
        ST_DONE,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        MD_INIT,
        MD_POLL,
        MD_SET
    } mode_e;

    // Source of the write data byte for a table step
    typedef enum logic [2:0] {
        DS_ZERO,
        DS_WP_ON,
        DS_SH_SEC,
        DS_SET_SEC,
        DS_SET_MIN,
        DS_SET_HR
    } dsel_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] addr;
        dsel_e      dsel;
        logic       last;
    } rom_ent_t;

endpackage

// File: rtl/ds1302_ctrl_module_seq_rom.sv
// Sequence table: maps (mode, step) to the transaction to issue.
// Purely combinational; the FSM walks the steps and decides early exits.
module ds1302_seq_rom
    import ds1302_ctrl_module_pkg::*;
(
    input  mode_e      i_mode,
    input  logic [2:0] i_step,
    output rom_ent_t   o_ent
);

    // Table lookup; unused slots decode to an idle, terminating entry
    always_comb begin
        o_ent = '{op: OP_IDLE, addr: 8'h00, dsel: DS_ZERO, last: 1'b1};
        unique case (i_mode)
            MD_INIT: begin
                case (i_step)
                    3'd0: o_ent = '{op: OP_WR, addr: ADDR_WP,    dsel: DS_ZERO,   last: 1'b0};
                    3'd1: o_ent = '{op: OP_RD, addr: ADDR_SEC_R, dsel: DS_ZERO,   last: 1'b0};
                    3'd2: o_ent = '{op: OP_WR, addr: ADDR_SEC_W, dsel: DS_SH_SEC, last: 1'b1};
                    default: ;
                endcase
            end
            MD_POLL: begin
                case (i_step)
                    3'd0: o_ent = '{op: OP_RD, addr: ADDR_SEC_R, dsel: DS_ZERO, last: 1'b0};
                    3'd1: o_ent = '{op: OP_RD, addr: ADDR_MIN_R, dsel: DS_ZERO, last: 1'b0};
                    3'd2: o_ent = '{op: OP_RD, addr: ADDR_HR_R,  dsel: DS_ZERO, last: 1'b1};
                    default: ;
                endcase
            end
            MD_SET: begin
                case (i_step)
                    3'd0: o_ent = '{op: OP_WR, addr: ADDR_WP,    dsel: DS_ZERO,    last: 1'b0};
                    3'd1: o_ent = '{op: OP_WR, addr: ADDR_SEC_W, dsel: DS_SET_SEC, last: 1'b0};
                    3'd2: o_ent = '{op: OP_WR, addr: ADDR_MIN_W, dsel: DS_SET_MIN, last: 1'b0};
                    3'd3: o_ent = '{op: OP_WR, addr: ADDR_HR_W,  dsel: DS_SET_HR,  last: 1'b0};
                    3'd4: o_ent = '{op: OP_WR, addr: ADDR_WP,    dsel: DS_WP_ON,   last: 1'b1};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ds1302_ctrl_module.sv
// DS1302 command sequencer. Runs the init sequence after reset, polls
// sec/min/hour periodically and serves time-set requests between polls,
// issuing one byte transaction at a time to the engine.
module ds1302_ctrl_module
    import ds1302_ctrl_module_pkg::*;
#(
    parameter int unsigned           PCNT_W      = 24,
    parameter logic [PCNT_W-1:0]     POLL_CYCLES = PCNT_W'(5_000_000)
)(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       set_req,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_ack,
    output logic [7:0] time_hour,
    output logic [7:0] time_min,
    output logic [7:0] time_sec,
    output logic       time_valid,
    output logic       busy,
    output logic [1:0] func_start_sig,
    output logic [7:0] words_addr,
    output logic [7:0] write_data,
    input  logic [7:0] read_data,
    input  logic       func_done_sig
);

    localparam logic [PCNT_W-1:0] LP_POLL_LAST = POLL_CYCLES - 1'b1;

    state_e            r_state;
    mode_e             r_mode;
    logic [2:0]        r_step;
    logic [PCNT_W-1:0] r_cnt;
    logic              r_set_pend;
    logic [7:0]        r_set_h, r_set_m, r_set_s;
    logic [7:0]        r_sh_sec, r_sh_min;

    rom_ent_t          w_ent;
    logic [7:0]        w_wdata;
    logic              w_set_active;
    logic              w_set_accept;
    logic              w_init_skip;

    ds1302_seq_rom u_rom (
        .i_mode (r_mode),
        .i_step (r_step),
        .o_ent  (w_ent)
    );

    // A SET sequence in flight blocks new requests, as does one already pending
    assign w_set_active = (r_mode == MD_SET) &&
                          ((r_state == ST_ISSUE) || (r_state == ST_DONE) || (r_state == ST_GAP));
    assign w_set_accept = set_req && !r_set_pend && !w_set_active;

    // Init skips the CH-clearing write when the oscillator is already running
    assign w_init_skip  = (r_mode == MD_INIT) && (w_ent.op == OP_RD) && !read_data[7];

    // Write data source for the current table step
    always_comb begin
        w_wdata = 8'h00;
        unique case (w_ent.dsel)
            DS_ZERO:    w_wdata = WP_OFF;
            DS_WP_ON:   w_wdata = WP_ON;
            DS_SH_SEC:  w_wdata = r_sh_sec & 8'h7F;
            DS_SET_SEC: w_wdata = r_set_s & 8'h7F;
            DS_SET_MIN: w_wdata = r_set_m & 8'h7F;
            DS_SET_HR:  w_wdata = r_set_h & 8'h3F;
            default:    w_wdata = 8'h00;
        endcase
    end

    // Latch requested time values when a set request is accepted
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_set_h <= 8'h00;
            r_set_m <= 8'h00;
            r_set_s <= 8'h00;
        end else if (w_set_accept) begin
            r_set_h <= set_hour;
            r_set_m <= set_min;
            r_set_s <= set_sec;
        end
    end

    // Main sequencer: issue / wait-done / gap handshake plus poll timer
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state        <= ST_INIT;
            r_mode         <= MD_INIT;
            r_step         <= 3'd0;
            r_cnt          <= '0;
            r_set_pend     <= 1'b0;
            r_sh_sec       <= 8'h00;
            r_sh_min       <= 8'h00;
            set_ack        <= 1'b0;
            time_hour      <= 8'h00;
            time_min       <= 8'h00;
            time_sec       <= 8'h00;
            time_valid     <= 1'b0;
            busy           <= 1'b0;
            func_start_sig <= OP_IDLE;
            words_addr     <= 8'h00;
            write_data     <= 8'h00;
        end else begin
            time_valid <= 1'b0;
            set_ack    <= 1'b0;
            if (w_set_accept)
                r_set_pend <= 1'b1;

            unique case (r_state)
                ST_INIT: begin
                    r_mode  <= MD_INIT;
                    r_step  <= 3'd0;
                    busy    <= 1'b1;
                    r_state <= ST_ISSUE;
                end
                ST_WAIT: begin
                    busy <= 1'b0;
                    if (r_set_pend) begin
                        // a pending set beats a poll that falls due in the same cycle
                        r_mode     <= MD_SET;
                        r_step     <= 3'd0;
                        r_cnt      <= '0;
                        r_set_pend <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end else if (r_cnt == LP_POLL_LAST) begin
                        r_mode  <= MD_POLL;
                        r_step  <= 3'd0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    func_start_sig <= w_ent.op;
                    words_addr     <= w_ent.addr;
                    write_data     <= w_wdata;
                    r_state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (func_done_sig) begin
                        func_start_sig <= OP_IDLE;
                        if (w_ent.op == OP_RD) begin
                            if (w_ent.addr == ADDR_SEC_R) r_sh_sec <= read_data;
                            if (w_ent.addr == ADDR_MIN_R) r_sh_min <= read_data;
                        end
                        if (w_ent.last || w_init_skip) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= '0;
                            busy    <= 1'b0;
                            if (r_mode == MD_POLL) begin
                                // hour arrives on this last read, so take it straight from the bus
                                time_sec   <= r_sh_sec & 8'h7F;
                                time_min   <= r_sh_min & 8'h7F;
                                time_hour  <= read_data & 8'h3F;
                                time_valid <= 1'b1;
                            end
                            if (r_mode == MD_SET)
                                set_ack <= 1'b1;
                        end else begin
                            r_step  <= r_step + 3'd1;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // one idle cycle so the engine re-arms before the next start
                    r_state <= ST_ISSUE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ds1302_ctrl_module.sv
// Bench for ds1302_ctrl_module: a behavioural byte engine with a DS1302
// register file answers transactions; expected transactions and time
// reports are queued by the stimulus and popped by monitors.
module tb_ds1302_ctrl_module;

    localparam int LAT = 6;

    logic       CLK, RSTn;
    logic       set_req;
    logic [7:0] set_hour, set_min, set_sec;
    logic       set_ack;
    logic [7:0] time_hour, time_min, time_sec;
    logic       time_valid, busy;
    logic [1:0] func_start_sig;
    logic [7:0] words_addr, write_data, read_data;
    logic       func_done_sig;

    ds1302_ctrl_module #(.PCNT_W(24), .POLL_CYCLES(24'd40)) dut (
        .CLK(CLK), .RSTn(RSTn), .set_req(set_req),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_ack(set_ack), .time_hour(time_hour), .time_min(time_min),
        .time_sec(time_sec), .time_valid(time_valid), .busy(busy),
        .func_start_sig(func_start_sig), .words_addr(words_addr),
        .write_data(write_data), .read_data(read_data),
        .func_done_sig(func_done_sig)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int n_pass = 0, n_total = 0;
    int tv_cnt = 0, ack_cnt = 0;
    logic [17:0] exp_q[$];
    logic [23:0] tq[$];
    logic [7:0]  regs [0:31];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    function automatic logic [17:0] tx(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    task automatic push_poll(input logic [23:0] t);
        exp_q.push_back(tx(2'b01, 8'h81, 8'h00));
        exp_q.push_back(tx(2'b01, 8'h83, 8'h00));
        exp_q.push_back(tx(2'b01, 8'h85, 8'h00));
        tq.push_back(t);
    endtask

    // Engine model: accepts a start only after seeing idle, checks the
    // command stays stable, answers with a done pulse after LAT cycles
    bit eng_busy, prev_idle, held_ok;
    int eng_cnt;
    logic [1:0] cur_op;
    logic [7:0] cur_addr, cur_data;
    always @(negedge CLK) begin
        if (!RSTn) begin
            eng_busy = 0; prev_idle = 1; func_done_sig = 0; read_data = 8'h00;
        end else begin
            func_done_sig = 0;
            if (!eng_busy) begin
                if (func_start_sig != 2'b00) begin
                    check("idle_before_issue", {31'd0, prev_idle}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_txn actual=%h required=none",
                                 {func_start_sig, words_addr, write_data});
                    end else
                        check("txn", {14'd0, func_start_sig, words_addr, write_data},
                              {14'd0, exp_q.pop_front()});
                    cur_op = func_start_sig; cur_addr = words_addr; cur_data = write_data;
                    held_ok = 1; eng_cnt = LAT; eng_busy = 1;
                end
            end else begin
                if (func_start_sig !== cur_op || words_addr !== cur_addr || write_data !== cur_data)
                    held_ok = 0;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    check("hold_until_done", {31'd0, held_ok}, 32'd1);
                    func_done_sig = 1;
                    if (cur_op == 2'b01) read_data = regs[cur_addr[5:1]];
                    else begin regs[cur_addr[5:1]] = cur_data; read_data = 8'h00; end
                    eng_busy = 0;
                end
            end
            prev_idle = (func_start_sig == 2'b00);
        end
    end

    // Time / ack monitor
    always @(negedge CLK) begin
        if (RSTn) begin
            if (time_valid) begin
                tv_cnt++;
                if (tq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_time_valid actual=%h required=none",
                             {time_hour, time_min, time_sec});
                end else
                    check("time", {8'd0, time_hour, time_min, time_sec}, {8'd0, tq.pop_front()});
            end
            if (set_ack) ack_cnt++;
        end
    end

    task automatic wait_tv(input int n);
        for (int i = 0; i < 3000 && tv_cnt < n; i++) @(negedge CLK);
        check("time_valid_count", tv_cnt, n);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_busy"},  {31'd0, busy}, 32'd0);
        check({nm, "_start"}, {30'd0, func_start_sig}, 32'd0);
        check({nm, "_addr_data"}, {16'd0, words_addr, write_data}, 32'd0);
        check({nm, "_time"}, {8'd0, time_hour, time_min, time_sec}, 32'd0);
        check({nm, "_pulses"}, {30'd0, time_valid, set_ack}, 32'd0);
    endtask

    task automatic pulse_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hour = h; set_min = m; set_sec = s; set_req = 1'b1;
        @(negedge CLK);
        set_req = 1'b0;
    endtask

    initial begin
        bit found;
        RSTn = 1'b0; set_req = 1'b0; set_hour = 0; set_min = 0; set_sec = 0;
        for (int i = 0; i < 32; i++) regs[i] = 8'h00;
        regs[0] = 8'h80; regs[1] = 8'h34; regs[2] = 8'h12;
        repeat (3) @(negedge CLK);
        check_zero_outputs("reset");

        // init with CH set, then first poll
        exp_q.push_back(tx(2'b10, 8'h8E, 8'h00));
        exp_q.push_back(tx(2'b01, 8'h81, 8'h00));
        exp_q.push_back(tx(2'b10, 8'h80, 8'h00));
        push_poll({8'h12, 8'h34, 8'h00});
        RSTn = 1'b1;
        wait_tv(1);
        check("busy_idle_after_poll", {31'd0, busy}, 32'd0);
        check("ch_cleared", {24'd0, regs[0]}, 32'h00);

        // set request mid-poll; poll completes first, then SET, then next poll
        push_poll({8'h12, 8'h34, 8'h00});
        exp_q.push_back(tx(2'b10, 8'h8E, 8'h00));
        exp_q.push_back(tx(2'b10, 8'h80, 8'h50));
        exp_q.push_back(tx(2'b10, 8'h82, 8'h59));
        exp_q.push_back(tx(2'b10, 8'h84, 8'h23));
        exp_q.push_back(tx(2'b10, 8'h8E, 8'h80));
        push_poll({8'h23, 8'h59, 8'h50});
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge CLK);
            if (func_start_sig == 2'b01 && words_addr == 8'h83) found = 1;
        end
        check("saw_poll_R83", {31'd0, found}, 32'd1);
        pulse_set(8'h23, 8'h59, 8'h50);
        pulse_set(8'h22, 8'h22, 8'h22);   // while pending: must be ignored
        wait_tv(3);
        check("one_set_ack", ack_cnt, 1);

        // reset in the middle of the minute write of a SET
        exp_q.push_back(tx(2'b10, 8'h8E, 8'h00));
        exp_q.push_back(tx(2'b10, 8'h80, 8'h03));
        exp_q.push_back(tx(2'b10, 8'h82, 8'h02));
        pulse_set(8'h01, 8'h02, 8'h03);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge CLK);
            if (func_start_sig == 2'b10 && words_addr == 8'h82) found = 1;
        end
        check("saw_W82", {31'd0, found}, 32'd1);
        @(negedge CLK);
        #2 RSTn = 1'b0;
        #1 check_zero_outputs("async_reset");
        check("aborted_min_unwritten", {24'd0, regs[1]}, 32'h59);

        // restart: CH set in sec=D9, hour reg 92 exercises the masks
        regs[0] = 8'hD9; regs[1] = 8'h07; regs[2] = 8'h92;
        exp_q.push_back(tx(2'b10, 8'h8E, 8'h00));
        exp_q.push_back(tx(2'b01, 8'h81, 8'h00));
        exp_q.push_back(tx(2'b10, 8'h80, 8'h59));
        push_poll({8'h12, 8'h07, 8'h59});
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        wait_tv(4);
        check("ch_cleared_2", {24'd0, regs[0]}, 32'h59);

        // restart with CH already clear: init skips the seconds write
        RSTn = 1'b0;
        regs[0] = 8'h45;
        exp_q.push_back(tx(2'b10, 8'h8E, 8'h00));
        exp_q.push_back(tx(2'b01, 8'h81, 8'h00));
        push_poll({8'h12, 8'h07, 8'h45});
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        wait_tv(5);
        check("sec_untouched", {24'd0, regs[0]}, 32'h45);
        check("txn_queue_drained", exp_q.size(), 0);
        check("time_queue_drained", tq.size(), 0);
        check("total_set_acks", ack_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
